cpu_phase_sequencer: RTL and testbench
======================================

// Module: cpu_phase_sequencer
// PURPOSE
//  Instruction sequencer for the 8-bit accumulator CPU; downstream consumer of the four phase strobes clock_1..clock_4.
//  Each strobe is a 1-clk pulse in order 1->2->3->4; full cycle is 10 clk. Phases: 1 fetch, 2 decode, 3 execute, 4 writeback.
//  Owns PC, IR, ACC and Z flag; drives async-read program memory; one instruction retires per phase cycle.
// PARAMETERS
//  ACC_W     8   accumulator/out_data width; immediates zero-extended to ACC_W
//  RESET_PC  0   PC value loaded on reset (5-bit)
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst_n      in   1      synchronous reset, active low
//  clock_1    in   1      phase-1 strobe (fetch)
//  clock_2    in   1      phase-2 strobe (decode)
//  clock_3    in   1      phase-3 strobe (execute)
//  clock_4    in   1      phase-4 strobe (writeback)
//  imem_addr  out  5      program address, equals pc register
//  imem_data  in   8      instruction; async read, valid same clk as imem_addr
//  acc        out  ACC_W  accumulator
//  zero       out  1      Z flag, set when acc==0 after writeback
//  out_data   out  ACC_W  OUT port value
//  out_valid  out  1      1-clk pulse when OUT retires
//  halted     out  1      high in HALT state
//  phase_err  out  1      sticky, strobe ordering violation
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): pc=RESET_PC, ir=0, acc=0, zero=1, out_data=0, out_valid=0, halted=0, phase_err=0, state=W1.
//  Instr: [7:5] opcode, [4:0] imm5. 000 NOP; 001 LDI acc=imm; 010 ADD acc+=imm; 011 SUB acc-=imm;
//   100 JMP pc=imm; 101 JZ pc=(zero?imm:pc+1); 110 OUT out_data=acc; 111 HALT.
//  Arithmetic modulo 2^ACC_W, no carry out. Non-jump pc=pc+1, 5-bit wrap 31->0. Z updated only by LDI/ADD/SUB.
//  FSM states W1,W2,W3,W4,HALT; strobe phase n valid only in Wn:
//   W1+clock_1: ir<=imem_data -> W2.   W2+clock_2: latch opcode/imm, compute next-pc candidate -> W3.
//   W3+clock_3: ALU result to internal res reg -> W4.
//   W4+clock_4: commit acc/zero/pc/out_data; out_valid=1 next clk only; HALT -> HALT, else -> W1.
//  Retire latency: architectural state visible clk after clock_4 strobe. No strobe: hold state.
//  W1 ignores lone clock_2/3/4 silently (startup resync, no error).
//  W2..W4: wrong lone strobe -> phase_err=1, discard instr (pc/acc/zero unchanged), -> W1.
//  Any state except HALT: >1 strobe same clk -> phase_err=1, discard, -> W1.
//  HALT: all strobes ignored, halted=1, outputs frozen; exit only via rst_n.
//  phase_err cleared only by reset. Reset mid-instruction abandons it with no partial commit.
// CONFIGURATION
//  CPU_SEQ_INSTR_COUNT_EN defined: adds output instr_count [15:0], reset 0, +1 per retire (incl. HALT), saturates at 16'hFFFF;
//   discarded instrs not counted.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset: rst_n=0 3 clk -> pc=0, acc=0, zero=1, halted=0, phase_err=0, out_valid=0, imem_addr=0.
//  2 Prog LDI 5;ADD 3;OUT;HALT, 10-clk strobes -> out_data=8, out_valid 1 clk after 3rd clock_4; halted after 4th, pc=3.
//  3 LDI 1;SUB 2 -> acc=0xFF, zero=0; LDI 0;JZ 7 -> pc=7; LDI 1;JZ 9 -> pc=pc+1.
//  4 JMP 31; mem[31]=NOP -> pc=31 then 0 after NOP retires (wrap).
//  5 clock_1 then clock_3 -> phase_err=1, pc/acc unchanged, state W1; clock_1+clock_2 same clk in W1 -> phase_err=1.
//  6 rst_n low 1 clk after clock_2 -> reset values; then clock_3,clock_4 before clock_1 -> ignored, phase_err=0.

Source files
------------

// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: instruction sequencer for the 8-bit accumulator CPU.
// Consumes the four phase strobes clock_1..clock_4 (fetch, decode, execute,
// writeback) and retires one instruction per strobe cycle. Owns PC, IR, ACC
// and the Z flag, and drives an async-read program memory.
// Optional feature: define CPU_SEQ_INSTR_COUNT_EN to add a saturating 16-bit
// retired-instruction counter on output instr_count.
module cpu_phase_sequencer #(
  parameter int unsigned ACC_W    = 8,
  parameter logic [4:0]  RESET_PC = 5'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clock_1,
  input  logic             clock_2,
  input  logic             clock_3,
  input  logic             clock_4,
  output logic [4:0]       imem_addr,
  input  logic [7:0]       imem_data,
  output logic [ACC_W-1:0] acc,
  output logic             zero,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  output logic             halted,
  output logic             phase_err
`ifdef CPU_SEQ_INSTR_COUNT_EN
  ,
  output logic [15:0]      instr_count
`endif
);

  typedef enum logic [2:0] {S_W1, S_W2, S_W3, S_W4, S_HALT} state_e;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LDI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_JMP  = 3'b100,
    OP_JZ   = 3'b101,
    OP_OUT  = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  state_e           state_q, state_d;
  logic [4:0]       pc_q, pc_d;
  logic [7:0]       ir_q, ir_d;
  opcode_e          op_q, op_d;
  logic [4:0]       imm_q, imm_d;
  logic [4:0]       npc_q, npc_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             zero_q, zero_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             perr_q, perr_d;
`ifdef CPU_SEQ_INSTR_COUNT_EN
  logic [15:0]      cnt_q, cnt_d;
`endif

  logic [3:0] strobes;
  logic       any_strobe;
  logic       multi_strobe;

  assign strobes      = {clock_4, clock_3, clock_2, clock_1};
  assign any_strobe   = |strobes;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_strobe = |(strobes & (strobes - 4'd1));

  // Next-state and datapath: one strobe advances one phase; misordered or
  // simultaneous strobes abandon the instruction without any commit.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    op_d        = op_q;
    imm_d       = imm_q;
    npc_d       = npc_q;
    res_d       = res_q;
    acc_d       = acc_q;
    zero_d      = zero_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    perr_d      = perr_q;
`ifdef CPU_SEQ_INSTR_COUNT_EN
    cnt_d       = cnt_q;
`endif

    if (state_q != S_HALT) begin
      if (multi_strobe) begin
        perr_d  = 1'b1;
        state_d = S_W1;
      end else begin
        case (state_q)
          S_W1: begin
            // Lone late strobes here are startup resync, not errors.
            if (clock_1) begin
              ir_d    = imem_data;
              state_d = S_W2;
            end
          end
          S_W2: begin
            if (clock_2) begin
              op_d  = opcode_e'(ir_q[7:5]);
              imm_d = ir_q[4:0];
              case (opcode_e'(ir_q[7:5]))
                OP_JMP:  npc_d = ir_q[4:0];
                OP_JZ:   npc_d = zero_q ? ir_q[4:0] : pc_q + 5'd1;
                OP_HALT: npc_d = pc_q;
                default: npc_d = pc_q + 5'd1;
              endcase
              state_d = S_W3;
            end else if (any_strobe) begin
              perr_d  = 1'b1;
              state_d = S_W1;
            end
          end
          S_W3: begin
            if (clock_3) begin
              case (op_q)
                OP_LDI:  res_d = ACC_W'(imm_q);
                OP_ADD:  res_d = acc_q + ACC_W'(imm_q);
                OP_SUB:  res_d = acc_q - ACC_W'(imm_q);
                default: res_d = acc_q;
              endcase
              state_d = S_W4;
            end else if (any_strobe) begin
              perr_d  = 1'b1;
              state_d = S_W1;
            end
          end
          S_W4: begin
            if (clock_4) begin
              pc_d = npc_q;
              if (op_q == OP_LDI || op_q == OP_ADD || op_q == OP_SUB) begin
                acc_d  = res_q;
                zero_d = (res_q == '0);
              end
              if (op_q == OP_OUT) begin
                out_data_d  = acc_q;
                out_valid_d = 1'b1;
              end
`ifdef CPU_SEQ_INSTR_COUNT_EN
              if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`endif
              state_d = (op_q == OP_HALT) ? S_HALT : S_W1;
            end else if (any_strobe) begin
              perr_d  = 1'b1;
              state_d = S_W1;
            end
          end
          default: state_d = S_W1;
        endcase
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= S_W1;
      pc_q        <= RESET_PC;
      ir_q        <= 8'd0;
      op_q        <= OP_NOP;
      imm_q       <= 5'd0;
      npc_q       <= RESET_PC;
      res_q       <= '0;
      acc_q       <= '0;
      zero_q      <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      perr_q      <= 1'b0;
`ifdef CPU_SEQ_INSTR_COUNT_EN
      cnt_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      op_q        <= op_d;
      imm_q       <= imm_d;
      npc_q       <= npc_d;
      res_q       <= res_d;
      acc_q       <= acc_d;
      zero_q      <= zero_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      perr_q      <= perr_d;
`ifdef CPU_SEQ_INSTR_COUNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign imem_addr = pc_q;
  assign acc       = acc_q;
  assign zero      = zero_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == S_HALT);
  assign phase_err = perr_q;
`ifdef CPU_SEQ_INSTR_COUNT_EN
  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb_cpu_phase_sequencer: directed bench for cpu_phase_sequencer. An ISA
// model pushes the expected architectural state of each instruction into a
// scoreboard queue when its strobe cycle starts; the entry is popped and
// compared one clk after the clock_4 strobe.
module tb_cpu_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clock_1, clock_2, clock_3, clock_4;
  logic [4:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] acc;
  logic       zero;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;
  logic       phase_err;
`ifdef CPU_SEQ_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  logic [7:0] mem [32];
  assign imem_data = mem[imem_addr];

  cpu_phase_sequencer #(.ACC_W(8), .RESET_PC(5'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clock_1   (clock_1),
    .clock_2   (clock_2),
    .clock_3   (clock_3),
    .clock_4   (clock_4),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .acc       (acc),
    .zero      (zero),
    .out_data  (out_data),
    .out_valid (out_valid),
    .halted    (halted),
    .phase_err (phase_err)
`ifdef CPU_SEQ_INSTR_COUNT_EN
    ,
    .instr_count (instr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [4:0] pc;
    logic [7:0] acc;
    logic       zero;
    logic [7:0] out_data;
    logic       ov;
    logic       halted;
    logic       perr;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference ISA state.
  logic [4:0] m_pc;
  logic [7:0] m_acc;
  logic       m_zero;
  logic [7:0] m_out;
  logic       m_halt;
  logic       m_err;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_pc = 5'd0; m_acc = 8'd0; m_zero = 1'b1; m_out = 8'd0;
    m_halt = 1'b0; m_err = 1'b0;
  endtask

  // Retire the instruction at m_pc in the model and queue its expected state.
  task automatic model_retire(input string tag);
    exp_t       e;
    logic [7:0] ins;
    logic [2:0] op;
    logic [4:0] imm;
    logic [4:0] pc_inc;
    e.ov = 1'b0;
    if (!m_halt) begin
      ins    = mem[m_pc];
      op     = ins[7:5];
      imm    = ins[4:0];
      pc_inc = m_pc + 5'd1;
      case (op)
        3'b001: begin m_acc = {3'b000, imm}; m_zero = (m_acc == 8'd0); m_pc = pc_inc; end
        3'b010: begin m_acc = m_acc + {3'b000, imm}; m_zero = (m_acc == 8'd0); m_pc = pc_inc; end
        3'b011: begin m_acc = m_acc - {3'b000, imm}; m_zero = (m_acc == 8'd0); m_pc = pc_inc; end
        3'b100: m_pc = imm;
        3'b101: m_pc = m_zero ? imm : pc_inc;
        3'b110: begin m_out = m_acc; e.ov = 1'b1; m_pc = pc_inc; end
        3'b111: m_halt = 1'b1;
        default: m_pc = pc_inc;
      endcase
    end
    e.tag = tag; e.pc = m_pc; e.acc = m_acc; e.zero = m_zero;
    e.out_data = m_out; e.halted = m_halt; e.perr = m_err;
    sb.push_back(e);
  endtask

  // Drive one clk of strobes (bits 3..0 = clock_4..clock_1), return #1 after
  // the sampling edge so registered outputs are stable.
  task automatic strobe(input logic [3:0] s);
    {clock_4, clock_3, clock_2, clock_1} = s;
    @(posedge clk);
    #1;
    {clock_4, clock_3, clock_2, clock_1} = 4'b0000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) strobe(4'b0000);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic compare_state(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".pc"},        32'(imem_addr), 32'(e.pc));
      check({e.tag, ".acc"},       32'(acc),       32'(e.acc));
      check({e.tag, ".zero"},      32'(zero),      32'(e.zero));
      check({e.tag, ".out_data"},  32'(out_data),  32'(e.out_data));
      check({e.tag, ".out_valid"}, 32'(out_valid), 32'(e.ov));
      check({e.tag, ".halted"},    32'(halted),    32'(e.halted));
      check({e.tag, ".phase_err"}, 32'(phase_err), 32'(e.perr));
    end
  endtask

  // One full 10-clk strobe cycle retiring one instruction.
  task automatic phase_cycle(input string tag);
    model_retire(tag);
    strobe(4'b0001); idle(1);
    strobe(4'b0010); idle(1);
    strobe(4'b0100); idle(1);
    strobe(4'b1000);
    compare_state(tag);
    idle(1);
    check({tag, ".ov_drop"}, 32'(out_valid), 32'd0);
    idle(2);
  endtask

  // Snapshot of the model without retiring anything.
  task automatic expect_now(input string tag);
    exp_t e;
    e.tag = tag; e.pc = m_pc; e.acc = m_acc; e.zero = m_zero;
    e.out_data = m_out; e.ov = 1'b0; e.halted = m_halt; e.perr = m_err;
    sb.push_back(e);
    compare_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    {clock_4, clock_3, clock_2, clock_1} = 4'b0000;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    // Reset values.
    mem[0] = 8'h25; mem[1] = 8'h43; mem[2] = 8'hC0; mem[3] = 8'hE0;
    do_reset(3);
    expect_now("reset");

    // LDI 5; ADD 3; OUT; HALT.
    phase_cycle("p2_ldi");
    phase_cycle("p2_add");
    phase_cycle("p2_out");
    phase_cycle("p2_halt");
    phase_cycle("p2_halt_hold");
    strobe(4'b0011);
    expect_now("p2_halt_multi_ignored");

    // SUB underflow, JZ taken, JZ not taken.
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'h21; mem[1] = 8'h62; mem[2] = 8'h20; mem[3] = 8'hA7;
    mem[7] = 8'h21; mem[8] = 8'hB4;
    do_reset(1);
    phase_cycle("p3_ldi1");
    phase_cycle("p3_sub2");
    phase_cycle("p3_ldi0");
    phase_cycle("p3_jz_taken");
    phase_cycle("p3_ldi1b");
    phase_cycle("p3_jz_not_taken");

    // JMP 31 then NOP wraps pc to 0.
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'h9F; mem[31] = 8'h00;
    do_reset(1);
    phase_cycle("p4_jmp31");
    phase_cycle("p4_nop_wrap");

    // Wrong lone strobe in W2 discards and returns to W1.
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'h25; mem[1] = 8'h43; mem[2] = 8'h22;
    do_reset(1);
    phase_cycle("p5_ldi");
    strobe(4'b0001); idle(1);
    strobe(4'b0100);
    m_err = 1'b1;
    expect_now("p5_wrong_strobe");
    phase_cycle("p5_resume_add");

    // Two strobes together in W1.
    do_reset(1);
    strobe(4'b0011);
    m_err = 1'b1;
    expect_now("p5_multi_w1");
    phase_cycle("p5_resume_ldi");

    // Reset mid-instruction, then early late strobes ignored in W1.
    do_reset(1);
    phase_cycle("p6_ldi");
    strobe(4'b0001); idle(1);
    strobe(4'b0010);
    do_reset(1);
    expect_now("p6_after_reset");
    strobe(4'b0100);
    strobe(4'b1000);
    expect_now("p6_resync_ignored");
    phase_cycle("p6_ldi_again");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
